nvram_port_arbiter: RTL and testbench
=====================================

NVRAM_PORT_ARBITER -- requirements
Module: nvram_port_arbiter

Interface
REQ-001 SHALL have parameter DUMP_W, default 10, hiscore address width.
REQ-002 SHALL have parameter NV_INDEX, default 8'd4, download index selecting NVRAM restore.
REQ-003 SHALL have parameter PAUSEPAD, default 2, settle cycles after pause acknowledge.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles waiting for pause acknowledge (8-bit).
REQ-005 SHALL have port clk_sys  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports dl_active in 1, dl_index in 8, dl_wr in 1, dl_addr in 16, dl_data in 8: download stream.
REQ-008 SHALL have ports hs_req in 1, hs_we in 1, hs_addr in DUMP_W, hs_wdata in 8: hiscore access request.
REQ-009 SHALL have ports hs_ack out 1, hs_rdata out 8, hs_err out 1: hiscore response.
REQ-010 SHALL have ports pause_req out 1, paused in 1: CPU pause handshake.
REQ-011 SHALL have ports mem_addr out 16, mem_wdata out 8, mem_rom_wr out 1, mem_nv_wr out 1, mem_nv_sel out 1, mem_rdata in 8: shared core port.
REQ-012 SHALL have port busy out 1, high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, DOWNLOAD, PAUSE_WAIT, PAD, ACCESS, READ_WAIT, RELEASE.
REQ-014 SHALL give dl_active absolute priority: any state -> DOWNLOAD on next edge when dl_active=1.
REQ-015 SHALL, in IDLE, go to PAUSE_WAIT when hs_req=1 and dl_active=0; set pause_req=1 on entry.
REQ-016 SHALL, in DOWNLOAD, register mem_addr=dl_addr, mem_wdata=dl_data, mem_nv_sel=(dl_index==NV_INDEX), mem_rom_wr=dl_wr&(dl_index==0), mem_nv_wr=dl_wr&(dl_index==NV_INDEX); one-cycle latency.
REQ-017 SHALL leave DOWNLOAD for IDLE on the first cycle dl_active=0, deasserting mem_nv_sel and write strobes the same edge.
REQ-018 SHALL, in PAUSE_WAIT, go to PAD when paused=1; after TIMEOUT cycles without paused, pulse hs_err one cycle, drop pause_req, go IDLE.
REQ-019 SHALL hold PAD exactly PAUSEPAD cycles (counter), then go ACCESS; PAUSEPAD=0 skips PAD.
REQ-020 SHALL, in ACCESS, drive mem_addr={zero-extend, hs_addr}, mem_nv_sel=1, mem_wdata=hs_wdata.
REQ-021 SHALL, for hs_we=1 in ACCESS, pulse mem_nv_wr and hs_ack together for one cycle.
REQ-022 SHALL, for hs_we=0, go ACCESS -> READ_WAIT; in READ_WAIT capture mem_rdata into hs_rdata and pulse hs_ack one cycle.
REQ-023 SHALL, the cycle after hs_ack, return to ACCESS if hs_req=1 (burst, pause held), else go RELEASE.
REQ-024 SHALL, in RELEASE, deassert pause_req and mem_nv_sel, go IDLE next cycle.
REQ-025 SHALL, if dl_active rises during PAUSE_WAIT/PAD/ACCESS/READ_WAIT, abort without hs_ack or hs_err, drop pause_req, and suppress any pending mem_nv_wr.
REQ-026 SHALL keep hs_rdata stable until the next read acknowledge.
REQ-027 SHALL never assert mem_rom_wr and mem_nv_wr in the same cycle.

Reset
REQ-028 SHALL, while reset_n=0, force state IDLE, counters 0, and all outputs 0 (mem_addr, mem_wdata, hs_rdata = 0).
REQ-029 SHALL resume operation on the first rising edge after reset_n deasserts; reset mid-access discards the request without hs_ack.

Verification
REQ-030 ROM download: dl_active=1, dl_index=0, dl_wr pulse addr 0x1234 data 0xA5 -> next cycle mem_addr=0x1234, mem_wdata=0xA5, mem_rom_wr=1, mem_nv_wr=0.
REQ-031 NVRAM restore: dl_index=4, dl_wr pulse addr 0x0010 -> mem_nv_wr=1, mem_nv_sel=1, mem_rom_wr=0.
REQ-032 Hiscore read: hs_req=1, hs_we=0, hs_addr=0x3F, paused after 5 cycles, mem_rdata=0x5A -> pause_req high, PAUSEPAD=2 wait, mem_addr=0x003F, hs_rdata=0x5A with hs_ack one pulse, then pause_req=0.
REQ-033 Burst write: 4 back-to-back hs_req writes -> 4 mem_nv_wr pulses, pause_req continuous, one PAUSE_WAIT only.
REQ-034 Timeout: hs_req=1, paused held 0 -> hs_err pulse at cycle TIMEOUT, pause_req=0, state IDLE.
REQ-035 Preemption: dl_active=1 during PAD -> no hs_ack, pause_req=0, DOWNLOAD next edge; reset_n pulse mid-READ_WAIT -> all outputs 0.

Source files
------------

// File: rtl/nvram_port_arbiter.sv
// Shares the core memory port between the download stream and hiscore NVRAM
// accesses; hiscore transfers are bracketed by a CPU pause handshake.
module nvram_port_arbiter #(
   parameter int unsigned DUMP_W   = 10,
   parameter logic [7:0]  NV_INDEX = 8'd4,
   parameter int unsigned PAUSEPAD = 2,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dl_active,
   input  logic [7:0]        dl_index,
   input  logic              dl_wr,
   input  logic [15:0]       dl_addr,
   input  logic [7:0]        dl_data,
   input  logic              hs_req,
   input  logic              hs_we,
   input  logic [DUMP_W-1:0] hs_addr,
   input  logic [7:0]        hs_wdata,
   output logic              hs_ack,
   output logic [7:0]        hs_rdata,
   output logic              hs_err,
   output logic              pause_req,
   input  logic              paused,
   output logic [15:0]       mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_rom_wr,
   output logic              mem_nv_wr,
   output logic              mem_nv_sel,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_DOWNLOAD, S_PAUSE_WAIT, S_PAD, S_ACCESS, S_READ_WAIT, S_RELEASE
   } state_t;

   localparam logic [7:0] PAD_LAST = 8'(PAUSEPAD - 1);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] addr_d;
   logic [7:0]  wdata_d, rdata_d;
   logic        sel_d, pause_d, ack_d, err_d, rom_wr_d, nv_wr_d;
   logic        load_acc, after_ack, is_nv, is_rom;

   assign is_nv  = (dl_index == NV_INDEX);
   assign is_rom = (dl_index == 8'd0);
   assign busy   = (state_q != S_IDLE);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = mem_addr;
      wdata_d   = mem_wdata;
      rdata_d   = hs_rdata;
      sel_d     = mem_nv_sel;
      pause_d   = pause_req;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      rom_wr_d  = 1'b0;
      nv_wr_d   = 1'b0;
      load_acc  = 1'b0;
      after_ack = 1'b0;
      if (dl_active) begin
         state_d  = S_DOWNLOAD;
         cnt_d    = '0;
         addr_d   = dl_addr;
         wdata_d  = dl_data;
         sel_d    = is_nv;
         pause_d  = 1'b0;
         rom_wr_d = dl_wr & is_rom;
         nv_wr_d  = dl_wr & is_nv & ~is_rom;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (hs_req) begin
                  state_d = S_PAUSE_WAIT;
                  pause_d = 1'b1;
                  cnt_d   = '0;
               end
            end
            S_DOWNLOAD: begin
               state_d = S_IDLE;
               sel_d   = 1'b0;
            end
            S_PAUSE_WAIT: begin
               if (paused) begin
                  cnt_d = '0;
                  if (PAUSEPAD == 0) load_acc = 1'b1;
                  else               state_d  = S_PAD;
               end else if (cnt_q == TO_LAST) begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
                  pause_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            S_PAD: begin
               if (cnt_q == PAD_LAST) load_acc = 1'b1;
               else                   cnt_d    = cnt_q + 8'd1;
            end
            // The acknowledge cycle is spent in the issuing state; hs_ack marks it.
            S_ACCESS: begin
               if (hs_ack) begin
                  after_ack = 1'b1;
               end else if (hs_we) begin
                  ack_d   = 1'b1;
                  nv_wr_d = 1'b1;
               end else begin
                  state_d = S_READ_WAIT;
               end
            end
            S_READ_WAIT: begin
               if (hs_ack) begin
                  after_ack = 1'b1;
               end else begin
                  ack_d   = 1'b1;
                  rdata_d = mem_rdata;
               end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
         if (after_ack) begin
            if (hs_req) begin
               load_acc = 1'b1;
            end else begin
               state_d = S_RELEASE;
               pause_d = 1'b0;
               sel_d   = 1'b0;
            end
         end
         if (load_acc) begin
            state_d = S_ACCESS;
            addr_d  = 16'(hs_addr);
            wdata_d = hs_wdata;
            sel_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         hs_rdata   <= '0;
         mem_nv_sel <= 1'b0;
         pause_req  <= 1'b0;
         hs_ack     <= 1'b0;
         hs_err     <= 1'b0;
         mem_rom_wr <= 1'b0;
         mem_nv_wr  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         hs_rdata   <= rdata_d;
         mem_nv_sel <= sel_d;
         pause_req  <= pause_d;
         hs_ack     <= ack_d;
         hs_err     <= err_d;
         mem_rom_wr <= rom_wr_d;
         mem_nv_wr  <= nv_wr_d;
      end
   end

endmodule

// File: tb/tb_nvram_port_arbiter.sv
// Directed bench: each scenario writes a per-cycle expected timeline from
// transaction arithmetic; a negedge process compares the DUT against it.
module tb_nvram_port_arbiter;

   localparam int N  = 1024;
   localparam int PP = 2;
   localparam int TO = 255;
   localparam int B_PAUSE = 0, B_BUSY = 1, B_ACK = 2, B_ERR = 3, B_ROM = 4, B_NVW = 5, B_SEL = 6;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        dl_active, dl_wr, hs_req, hs_we, paused;
   logic [7:0]  dl_index, dl_data, hs_wdata, mem_rdata;
   logic [15:0] dl_addr;
   logic [9:0]  hs_addr;
   logic        hs_ack, hs_err, pause_req, mem_rom_wr, mem_nv_wr, mem_nv_sel, busy;
   logic [7:0]  hs_rdata, mem_wdata;
   logic [15:0] mem_addr;

   nvram_port_arbiter #(.DUMP_W(10), .NV_INDEX(8'd4), .PAUSEPAD(PP), .TIMEOUT(TO)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .dl_active(dl_active), .dl_index(dl_index), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
      .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
      .hs_ack(hs_ack), .hs_rdata(hs_rdata), .hs_err(hs_err),
      .pause_req(pause_req), .paused(paused),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rom_wr(mem_rom_wr),
      .mem_nv_wr(mem_nv_wr), .mem_nv_sel(mem_nv_sel), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   // NVRAM contents as a fixed function of address (0x3F reads 0x5A).
   assign mem_rdata = mem_addr[7:0] ^ 8'h65;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   logic [6:0]  e_ctl   [N];
   logic        e_dchk  [N];
   logic [15:0] e_addr  [N];
   logic [7:0]  e_wdata [N];
   logic [7:0]  e_rdata [N];
   logic [6:0]  h_ctl   [N];
   logic [15:0] h_addr  [N];
   logic [7:0]  h_wdata [N];
   logic [7:0]  h_rdata [N];
   logic [6:0]  act_ctl;
   string ctl_name [7] = '{"pause_req", "busy", "hs_ack", "hs_err", "mem_rom_wr", "mem_nv_wr", "mem_nv_sel"};

   assign act_ctl = {mem_nv_sel, mem_nv_wr, mem_rom_wr, hs_err, hs_ack, busy, pause_req};

   int n_chk = 0, n_pass = 0;
   bit run_chk = 1'b0;

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
   endtask

   always @(negedge clk_sys) begin
      if (run_chk && cyc < N) begin
         h_ctl[cyc] = act_ctl; h_addr[cyc] = mem_addr; h_wdata[cyc] = mem_wdata; h_rdata[cyc] = hs_rdata;
         for (int b = 0; b < 7; b++) cmp(ctl_name[b], 16'(act_ctl[b]), 16'(e_ctl[cyc][b]));
         cmp("hs_rdata", 16'(hs_rdata), 16'(e_rdata[cyc]));
         if (e_dchk[cyc]) begin
            cmp("mem_addr", mem_addr, e_addr[cyc]);
            cmp("mem_wdata", 16'(mem_wdata), 16'(e_wdata[cyc]));
         end
      end
   end

   task automatic step();
      @(posedge clk_sys); #1;
   endtask

   task automatic mark(input int which, input int from, input int to);
      for (int i = from; i <= to; i++) if (i >= 0 && i < N) e_ctl[i][which] = 1'b1;
   endtask

   task automatic exp_data(input int c, input logic [15:0] a, input logic [7:0] d);
      if (c >= 0 && c < N) begin e_dchk[c] = 1'b1; e_addr[c] = a; e_wdata[c] = d; end
   endtask

   task automatic rdata_from(input int c, input logic [7:0] v);
      for (int i = c; i < N; i++) if (i >= 0) e_rdata[i] = v;
   endtask

   // Download beats i: addr a0+i, data d0+i, write strobe wrm[i]; registered one cycle later.
   task automatic dl_seq(input logic [7:0] idx, input int nb, input logic [15:0] a0,
                         input logic [7:0] d0, input logic [3:0] wrm, output int key);
      int s;
      s = cyc;
      for (int i = 0; i < nb; i++) begin
         mark(B_BUSY, s + 1 + i, s + 1 + i);
         if (idx == 8'd4) mark(B_SEL, s + 1 + i, s + 1 + i);
         if (wrm[i] && idx == 8'd0) mark(B_ROM, s + 1 + i, s + 1 + i);
         if (wrm[i] && idx == 8'd4) mark(B_NVW, s + 1 + i, s + 1 + i);
         exp_data(s + 1 + i, a0 + 16'(i), d0 + 8'(i));
      end
      for (int i = 0; i < nb; i++) begin
         dl_active = 1'b1; dl_index = idx; dl_wr = wrm[i];
         dl_addr = a0 + 16'(i); dl_data = d0 + 8'(i);
         step();
      end
      dl_active = 1'b0; dl_wr = 1'b0;
      step(); step();
      key = s + 1;
   endtask

   // Read: pause_req rises at g, paused seen pd cycles later, PP pad cycles, then
   // ACCESS (a), READ_WAIT (a+1), ack (a+2), RELEASE (a+3).
   task automatic hs_read(input logic [9:0] ad, input int pd, output int key);
      int s, g, a;
      s = cyc; g = s + 1; a = g + pd + PP;
      mark(B_PAUSE, g, a + 2); mark(B_BUSY, g, a + 3); mark(B_SEL, a, a + 2); mark(B_ACK, a + 2, a + 2);
      for (int c = a; c <= a + 2; c++) exp_data(c, 16'(ad), 8'h3C);
      rdata_from(a + 2, ad[7:0] ^ 8'h65);
      hs_req = 1'b1; hs_we = 1'b0; hs_addr = ad; hs_wdata = 8'h3C;
      repeat (pd) step();
      paused = 1'b1;
      while (cyc < a + 2) step();
      hs_req = 1'b0;
      step(); paused = 1'b0;
      step(); step();
      key = a + 2;
   endtask

   // Burst of nw writes: write k enters ACCESS at a+2k and acks at a+2k+1.
   task automatic hs_burst_wr(input int nw, input int pd, input logic [9:0] a0,
                              input logic [7:0] d0, output int first, output int last);
      int s, g, a;
      s = cyc; g = s + 1; a = g + pd + PP;
      mark(B_PAUSE, g, a + 2 * nw - 1); mark(B_BUSY, g, a + 2 * nw); mark(B_SEL, a, a + 2 * nw - 1);
      for (int k = 0; k < nw; k++) begin
         mark(B_ACK, a + 2 * k + 1, a + 2 * k + 1);
         mark(B_NVW, a + 2 * k + 1, a + 2 * k + 1);
         exp_data(a + 2 * k, 16'(a0) + 16'(k), d0 + 8'(k));
         exp_data(a + 2 * k + 1, 16'(a0) + 16'(k), d0 + 8'(k));
      end
      hs_req = 1'b1; hs_we = 1'b1; hs_addr = a0; hs_wdata = d0;
      repeat (pd) step();
      paused = 1'b1;
      for (int k = 1; k < nw; k++) begin
         while (cyc < a + 2 * k - 1) step();
         hs_addr = a0 + 10'(k); hs_wdata = d0 + 8'(k);
      end
      while (cyc < a + 2 * nw - 1) step();
      hs_req = 1'b0;
      step(); paused = 1'b0;
      step(); step();
      first = s; last = a + 2 * nw;
   endtask

   task automatic hs_timeout(output int key);
      int g;
      g = cyc + 1;
      mark(B_PAUSE, g, g + TO - 1); mark(B_BUSY, g, g + TO - 1); mark(B_ERR, g + TO, g + TO);
      hs_req = 1'b1; hs_we = 1'b0; hs_addr = 10'h055;
      while (cyc < g + TO) step();
      hs_req = 1'b0;
      step(); step();
      key = g;
   endtask

   task automatic preempt_pad(output int key);
      int g;
      g = cyc + 1;
      mark(B_PAUSE, g, g + 1); mark(B_BUSY, g, g + 2);
      exp_data(g + 2, 16'h0200, 8'h11);
      hs_req = 1'b1; hs_we = 1'b0; hs_addr = 10'h010;
      step(); paused = 1'b1;
      step();
      dl_active = 1'b1; dl_index = 8'd0; dl_wr = 1'b0; dl_addr = 16'h0200; dl_data = 8'h11; hs_req = 1'b0;
      step(); dl_active = 1'b0; paused = 1'b0;
      step(); step();
      key = g + 2;
   endtask

   task automatic preempt_write(output int key);
      int g, a;
      g = cyc + 1; a = g + 1 + PP;
      mark(B_PAUSE, g, a); mark(B_BUSY, g, a + 1); mark(B_SEL, a, a);
      exp_data(a, 16'h00AA, 8'h99); exp_data(a + 1, 16'h0300, 8'h22);
      hs_req = 1'b1; hs_we = 1'b1; hs_addr = 10'h0AA; hs_wdata = 8'h99;
      step(); paused = 1'b1;
      while (cyc < a) step();
      dl_active = 1'b1; dl_index = 8'd0; dl_wr = 1'b0; dl_addr = 16'h0300; dl_data = 8'h22; hs_req = 1'b0;
      step(); dl_active = 1'b0; paused = 1'b0;
      step(); step();
      key = a + 1;
   endtask

   // Reset lands in the READ_WAIT cycle (a+1) and is held through a+3.
   task automatic reset_mid_read(output int key);
      int g, a;
      g = cyc + 1; a = g + 1 + PP;
      mark(B_PAUSE, g, a); mark(B_BUSY, g, a); mark(B_SEL, a, a);
      exp_data(a, 16'h007E, 8'h44);
      for (int c = a + 1; c <= a + 3; c++) exp_data(c, 16'h0000, 8'h00);
      rdata_from(a + 1, 8'h00);
      hs_req = 1'b1; hs_we = 1'b0; hs_addr = 10'h07E; hs_wdata = 8'h44;
      step(); paused = 1'b1;
      while (cyc < a + 1) step();
      reset_n = 1'b0; hs_req = 1'b0; paused = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step(); step(); step();
      key = a + 1;
   endtask

   initial begin
      int k, k2, cnt, rises;
      reset_n = 1'b0;
      dl_active = 1'b0; dl_index = '0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
      hs_req = 1'b0; hs_we = 1'b0; hs_addr = '0; hs_wdata = '0; paused = 1'b0;
      for (int i = 0; i < N; i++) begin
         e_ctl[i] = '0; e_dchk[i] = 1'b0; e_addr[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0;
         h_ctl[i] = '0; h_addr[i] = '0; h_wdata[i] = '0; h_rdata[i] = '0;
      end
      for (int c = 1; c <= 3; c++) exp_data(c, 16'h0000, 8'h00);
      run_chk = 1'b1;
      step(); step(); step();
      reset_n = 1'b1;
      step(); step();

      dl_seq(8'd0, 2, 16'h1234, 8'hA5, 4'b0001, k);
      cmp("pin_rom_addr", h_addr[k], 16'h1234);
      cmp("pin_rom_wdata", 16'(h_wdata[k]), 16'h00A5);
      cmp("pin_rom_wr", 16'(h_ctl[k][B_ROM]), 16'h0001);
      cmp("pin_rom_nvwr", 16'(h_ctl[k][B_NVW]), 16'h0000);

      dl_seq(8'd4, 2, 16'h0010, 8'h77, 4'b0001, k);
      cmp("pin_nv_wr", 16'(h_ctl[k][B_NVW]), 16'h0001);
      cmp("pin_nv_sel", 16'(h_ctl[k][B_SEL]), 16'h0001);
      cmp("pin_nv_romwr", 16'(h_ctl[k][B_ROM]), 16'h0000);

      hs_read(10'h03F, 5, k);
      cmp("pin_read_rdata", 16'(h_rdata[k]), 16'h005A);
      cmp("pin_read_addr", h_addr[k], 16'h003F);
      cmp("pin_read_ack", 16'(h_ctl[k][B_ACK]), 16'h0001);
      cmp("pin_read_release", 16'(h_ctl[k + 1][B_PAUSE]), 16'h0000);

      hs_burst_wr(4, 2, 10'h100, 8'hC0, k, k2);
      cnt = 0; rises = 0;
      for (int i = k; i <= k2; i++) begin
         if (h_ctl[i][B_NVW]) cnt++;
         if (h_ctl[i][B_PAUSE] && !h_ctl[i - 1][B_PAUSE]) rises++;
      end
      cmp("pin_burst_nvwr", 16'(cnt), 16'd4);
      cmp("pin_burst_pause_rises", 16'(rises), 16'd1);

      hs_timeout(k);
      cmp("pin_to_err", 16'(h_ctl[k + 255][B_ERR]), 16'h0001);
      cmp("pin_to_noerr_early", 16'(h_ctl[k + 254][B_ERR]), 16'h0000);
      cmp("pin_to_pause_drop", 16'(h_ctl[k + 255][B_PAUSE]), 16'h0000);
      cmp("pin_to_idle", 16'(h_ctl[k + 255][B_BUSY]), 16'h0000);

      preempt_pad(k);
      cmp("pin_pad_noack", 16'(h_ctl[k][B_ACK]), 16'h0000);
      cmp("pin_pad_pause", 16'(h_ctl[k][B_PAUSE]), 16'h0000);
      cmp("pin_pad_dl_addr", h_addr[k], 16'h0200);

      preempt_write(k);
      cmp("pin_pw_nvwr", 16'(h_ctl[k][B_NVW]), 16'h0000);
      cmp("pin_pw_ack", 16'(h_ctl[k][B_ACK]), 16'h0000);

      hs_read(10'h2C1, 3, k);
      cmp("pin_read2_rdata", 16'(h_rdata[k]), 16'h00A4);

      reset_mid_read(k);
      cmp("pin_rst_rdata_before", 16'(h_rdata[k - 1]), 16'h00A4);
      cmp("pin_rst_rdata", 16'(h_rdata[k]), 16'h0000);
      cmp("pin_rst_ctl", 16'(h_ctl[k]), 16'h0000);
      cmp("pin_rst_addr", h_addr[k], 16'h0000);

      step();
      run_chk = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
